// File: rtl/bcd_exc3_pkg.sv
// ============================================================================
// Module      : bcd_exc3_pkg
// Description : FSM state type and digit-code constants for bcd_exc3_serial.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_exc3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] EXC3_OFFSET    = 4'd3;
  localparam logic [3:0] BCD_MAX        = 4'd9;
  localparam logic [3:0] EXC3_MIN       = 4'd3;
  localparam logic [3:0] EXC3_MAX       = 4'd12;
  localparam logic [3:0] INVALID_NIBBLE = 4'hF;

endpackage

`default_nettype wire

// File: rtl/bcd_exc3_digit.sv
// ============================================================================
// Module      : bcd_exc3_digit
// Description : Combinational single-nibble BCD <-> Excess-3 converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_exc3_digit
  import bcd_exc3_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dir,
  output logic [3:0] o_result,
  output logic       o_err
);

  // Anything outside the legal code range for the chosen direction is flagged.
  always_comb begin
    o_result = INVALID_NIBBLE;
    o_err    = 1'b1;
    if (!i_dir) begin
      if (i_nibble <= BCD_MAX) begin
        o_result = i_nibble + EXC3_OFFSET;
        o_err    = 1'b0;
      end
    end else begin
      if ((i_nibble >= EXC3_MIN) && (i_nibble <= EXC3_MAX)) begin
        o_result = i_nibble - EXC3_OFFSET;
        o_err    = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_exc3_serial.sv
// ============================================================================
// Module      : bcd_exc3_serial
// Description : Digit-serial BCD/Excess-3 word converter, one digit per clock.
//               Macro BCD_EXC3_REVERSE_EN adds the dir port (Excess-3 -> BCD).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_exc3_serial
  import bcd_exc3_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] out_data,
  output logic [N_DIGITS-1:0]   out_err,
  output logic                  busy
`ifdef BCD_EXC3_REVERSE_EN
  ,
  input  logic                  dir
`endif
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [4*N_DIGITS-1:0]   r_data;
  logic                    r_dir;
  logic [IDX_W-1:0]        r_idx;
  logic [4*N_DIGITS-1:0]   r_out_data;
  logic [N_DIGITS-1:0]     r_out_err;
  logic                    w_dir_in;
  logic [3:0]              w_nibble;
  logic [3:0]              w_result;
  logic                    w_err;

`ifdef BCD_EXC3_REVERSE_EN
  assign w_dir_in = dir;
`else
  assign w_dir_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CONV;
      CONV:    if (r_idx == c_last_idx) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Single shared converter; the digit index selects which nibble it sees.
  always_comb begin
    w_nibble = r_data[3:0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_nibble = r_data[i*4 +: 4];
    end
  end

  bcd_exc3_digit u_digit (
    .i_nibble (w_nibble),
    .i_dir    (r_dir),
    .o_result (w_result),
    .o_err    (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_dir      <= 1'b0;
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_err  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_dir      <= w_dir_in;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_err  <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_out_data[i*4 +: 4] <= w_result;
              r_out_err[i]         <= w_err;
            end
          end
          if (r_idx != c_last_idx) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out_data;
  assign out_err  = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_exc3_serial.sv
// ============================================================================
// Module      : tb_bcd_exc3_serial
// Description : Scoreboard bench for bcd_exc3_serial (N_DIGITS=4 and 1).
//               Reverse cases run when BCD_EXC3_REVERSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_exc3_serial;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, dir, sel;
  logic [15:0] in_data;

  logic        in_ready4, out_valid4, busy4;
  logic [15:0] out_data4;
  logic [3:0]  out_err4;
  logic        in_ready1, out_valid1, busy1;
  logic [3:0]  out_data1;
  logic [0:0]  out_err1;
  logic        iv4, iv1;

  logic        m_ready, m_valid, m_busy;
  logic [15:0] m_data;
  logic [3:0]  m_err;

  always #5 clk = ~clk;

  assign iv4     = in_valid & ~sel;
  assign iv1     = in_valid & sel;
  assign m_ready = sel ? in_ready1  : in_ready4;
  assign m_valid = sel ? out_valid1 : out_valid4;
  assign m_busy  = sel ? busy1      : busy4;
  assign m_data  = sel ? {12'h000, out_data1} : out_data4;
  assign m_err   = sel ? {3'b000, out_err1}   : out_err4;

  bcd_exc3_serial #(.N_DIGITS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .out_err   (out_err4),
    .busy      (busy4)
`ifdef BCD_EXC3_REVERSE_EN
    ,
    .dir       (dir)
`endif
  );

  bcd_exc3_serial #(.N_DIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .in_ready  (in_ready1),
    .in_data   (in_data[3:0]),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_err   (out_err1),
    .busy      (busy1)
`ifdef BCD_EXC3_REVERSE_EN
    ,
    .dir       (dir)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, result} for one nibble.
  function automatic logic [4:0] model(input logic [3:0] n, input logic d);
    if (!d) return (n < 4'd10) ? {1'b0, n + 4'd3} : {1'b1, 4'hF};
    return ((n >= 4'd3) && (n <= 4'd12)) ? {1'b0, n - 4'd3} : {1'b1, 4'hF};
  endfunction

  // Handshake one word; returns at the negedge just after the handshake edge.
  task automatic send(input logic [15:0] data, input logic d,
                      input logic [15:0] ed, input logic [3:0] ee);
    int w = 0;
    @(negedge clk);
    while (!m_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_send", {31'b0, m_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    dir      = d;
    sb.push_back('{ed, ee});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~data;
    dir      = ~d;
    check("in_ready_in_conv", {31'b0, m_ready}, 32'd0);
    check("busy_in_conv", {31'b0, m_busy}, 32'd1);
    check("out_cleared_in_conv", {16'b0, m_data}, 32'd0);
  endtask

  task automatic recv(input int exp_lat, input int hold);
    int   lat = 0;
    exp_t e;
    while (!m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat > 1 && sb.size() > 0)
        check("partial_write", {16'b0, m_data}, {28'b0, sb[0].d[3:0]});
    end
    check("latency", lat, exp_lat);
    if (m_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("out_data", {16'b0, m_data}, {16'b0, e.d});
      check("out_err", {28'b0, m_err}, {28'b0, e.e});
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        in_data  = 16'h9999;
        @(negedge clk);
        check("hold_data", {16'b0, m_data}, {16'b0, e.d});
        check("hold_err", {28'b0, m_err}, {28'b0, e.e});
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_in_ready", {31'b0, m_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_done", {31'b0, m_ready}, 32'd1);
      check("valid_after_done", {31'b0, m_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [4:0] m;
    bit         seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dir = 1'b0; sel = 1'b0;
    in_data = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready4}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid4}, 32'd0);
    check("rst_busy", {31'b0, busy4}, 32'd0);
    check("rst_out_data", {16'b0, out_data4}, 32'd0);
    check("rst_out_err", {28'b0, out_err4}, 32'd0);
    check("rst_in_ready1", {31'b0, in_ready1}, 32'd1);
    rst = 1'b0;

    send(16'h1987, 1'b0, 16'h4CBA, 4'b0000); recv(4, 0);
    send(16'h0A95, 1'b0, 16'h3FC8, 4'b0100); recv(4, 0);
    send(16'h2046, 1'b0, 16'h5379, 4'b0000); recv(4, 10);
    send(16'h9310, 1'b0, 16'hC643, 4'b0000); recv(4, 0);

    // Reset during the second CONV cycle abandons the word.
    send(16'h1234, 1'b0, 16'h4567, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("rst_conv_out_valid", {31'b0, out_valid4}, 32'd0);
    check("rst_conv_out_data", {16'b0, out_data4}, 32'd0);
    check("rst_conv_in_ready", {31'b0, in_ready4}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
    end
    check("rst_conv_no_result", {31'b0, seen}, 32'd0);

`ifdef BCD_EXC3_REVERSE_EN
    send(16'h4CBA, 1'b1, 16'h1987, 4'b0000); recv(4, 0);
    send(16'h3F20, 1'b1, 16'h0FFF, 4'b0111); recv(4, 0);
    send(16'h1987, 1'b0, 16'h4CBA, 4'b0000); recv(4, 0);
`endif

    sel = 1'b1;
    for (int n = 0; n < 16; n++) begin
      m = model(4'(n), 1'b0);
      send({12'h000, 4'(n)}, 1'b0, {12'h000, m[3:0]}, {3'b000, m[4]});
      recv(1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
